// File: rtl/snn_pkg.sv
// Shared tinySNN definitions: neuron state encoding and a constant-foldable clog2.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INTEG  = 2'd1,
        ST_REFRAC = 2'd2
    } snn_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wlif_sat_acc.sv
// Combinational membrane update: weighted channel sum, optional inhibitory split,
// proportional leak and clamp to [0, 2^p_width-1].
// Build option: WLIF_INHIB_EN makes channels with i_inhib=1 subtract their weight.
module wlif_sat_acc
    import snn_pkg::*;
#(
    parameter int unsigned p_width = 8,
    parameter int unsigned p_nbit  = 6,
    parameter int unsigned p_nsyn  = 4
) (
    input  logic [p_width-1:0]        i_vmem,
    input  logic                      i_tick,
    input  logic [p_nsyn-1:0]         i_event,
    input  logic [p_nsyn*p_width-1:0] i_weight,
    input  logic [p_nsyn-1:0]         i_inhib,
    output logic [p_width-1:0]        o_vn_c
);

    localparam int unsigned SW = p_width + clog2(p_nsyn);
    // Two extra bits: one for the carry of vl + S, one for the sign.
    localparam int unsigned AW = SW + 2;
    localparam logic [p_width-1:0] VMAX = '1;

    logic [SW-1:0]         sum_exc;
    logic [SW-1:0]         sum_inh;
    logic [p_width-1:0]    leak_amt;
    logic [p_width-1:0]    vl;
    logic signed [AW-1:0]  net;

`ifndef WLIF_INHIB_EN
    logic unused_inhib;
    assign unused_inhib = ^i_inhib;
`endif

    // Sum the weights of all active channels, split by polarity.
    always_comb begin
        sum_exc = '0;
        sum_inh = '0;
        for (int k = 0; k < int'(p_nsyn); k++) begin
            if (i_event[k]) begin
`ifdef WLIF_INHIB_EN
                if (i_inhib[k]) begin
                    sum_inh = sum_inh + SW'(i_weight[k*p_width +: p_width]);
                end else begin
                    sum_exc = sum_exc + SW'(i_weight[k*p_width +: p_width]);
                end
`else
                sum_exc = sum_exc + SW'(i_weight[k*p_width +: p_width]);
`endif
            end
        end
    end

    // Leak first (at least 1 per tick, never below 0), then add and clamp.
    always_comb begin
        leak_amt = i_vmem >> p_nbit;
        if (leak_amt == '0) begin
            leak_amt = p_width'(1);
        end
        vl = (i_tick && (i_vmem != '0)) ? (i_vmem - leak_amt) : i_vmem;
        net = $signed(AW'(vl)) + $signed(AW'(sum_exc)) - $signed(AW'(sum_inh));
        if (net[AW-1]) begin
            o_vn_c = '0;
        end else if (net > $signed(AW'(VMAX))) begin
            o_vn_c = VMAX;
        end else begin
            o_vn_c = net[p_width-1:0];
        end
    end

endmodule

// File: rtl/wlif_mc.sv
// Multi-channel weighted leaky integrate-and-fire neuron.
// Holds the IDLE/INTEG/REFRAC state machine, leak tick counter, refractory
// counter and registered outputs; the membrane arithmetic lives in wlif_sat_acc.
// Build option: WLIF_INHIB_EN enables inhibitory channels (port list unchanged).
module wlif_mc
    import snn_pkg::*;
#(
    parameter int unsigned p_width    = 8,
    parameter int unsigned p_nbit     = 6,
    parameter int unsigned p_nsyn     = 4,
    parameter int unsigned p_leak_div = 16,
    parameter int unsigned p_rfw      = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [p_nsyn-1:0]         i_event,
    input  logic [p_nsyn*p_width-1:0] i_weight,
    input  logic [p_nsyn-1:0]         i_inhib,
    input  logic [p_width-1:0]        i_thresh,
    input  logic [p_rfw-1:0]          i_refrac,
    output logic                      o_spike,
    output logic                      o_clr,
    output logic [p_width-1:0]        o_do,
    output logic                      o_busy
);

    localparam int unsigned LCW = (clog2(p_leak_div) == 0) ? 1 : clog2(p_leak_div);
    localparam logic [LCW-1:0] LC_LAST = LCW'(p_leak_div - 1);

    snn_state_e          state_q, state_d;
    logic [p_width-1:0]  vmem_q,  vmem_d;
    logic [LCW-1:0]      lcnt_q,  lcnt_d;
    logic [p_rfw-1:0]    rcnt_q,  rcnt_d;
    logic                spike_q, spike_d;
    logic                clr_q,   clr_d;
    logic                busy_q,  busy_d;

    logic                tick_c;
    logic [p_width-1:0]  vn_c;

    assign tick_c = (lcnt_q == LC_LAST);

    wlif_sat_acc #(
        .p_width (p_width),
        .p_nbit  (p_nbit),
        .p_nsyn  (p_nsyn)
    ) u_acc (
        .i_vmem   (vmem_q),
        .i_tick   (tick_c),
        .i_event  (i_event),
        .i_weight (i_weight),
        .i_inhib  (i_inhib),
        .o_vn_c   (vn_c)
    );

    // Next-state, membrane, counters and output pulses.
    always_comb begin
        state_d = state_q;
        vmem_d  = vmem_q;
        rcnt_d  = rcnt_q;
        spike_d = 1'b0;
        clr_d   = 1'b0;
        lcnt_d  = tick_c ? '0 : (lcnt_q + LCW'(1));

        case (state_q)
            ST_IDLE, ST_INTEG: begin
                if ((i_thresh != '0) && (vn_c >= i_thresh)) begin
                    spike_d = 1'b1;
                    clr_d   = 1'b1;
                    vmem_d  = '0;
                    rcnt_d  = i_refrac;
                    state_d = (i_refrac == '0) ? ST_IDLE : ST_REFRAC;
                end else begin
                    vmem_d  = vn_c;
                    state_d = (vn_c != '0) ? ST_INTEG : ST_IDLE;
                end
            end
            ST_REFRAC: begin
                // Events are dropped; leaving at count 1 reopens the input
                // exactly i_refrac cycles after the spike cycle.
                vmem_d = '0;
                rcnt_d = rcnt_q - p_rfw'(1);
                if (rcnt_q <= p_rfw'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vmem_d  = '0;
                rcnt_d  = '0;
            end
        endcase

        busy_d = (state_d == ST_REFRAC);
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            vmem_q  <= '0;
            lcnt_q  <= '0;
            rcnt_q  <= '0;
            spike_q <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vmem_q  <= vmem_d;
            lcnt_q  <= lcnt_d;
            rcnt_q  <= rcnt_d;
            spike_q <= spike_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
        end
    end

    assign o_spike = spike_q;
    assign o_clr   = clr_q;
    assign o_do    = vmem_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_wlif_mc.sv
// Scoreboard bench for wlif_mc: stimulus pushes expected {o_do, o_spike, o_clr, o_busy}
// per driven cycle; a monitor pops and compares after each rising edge.
module tb_wlif_mc;

    logic        clk;
    logic        rst;
    logic [3:0]  ev;
    logic [31:0] w;
    logic [3:0]  inh;
    logic [7:0]  thresh;
    logic [3:0]  refrac;
    logic        spike;
    logic        clr;
    logic [7:0]  vdo;
    logic        busy;

    typedef struct {
        logic [7:0] vdo;
        logic       sp;
        logic       cl;
        logic       bz;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    wlif_mc dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_event  (ev),
        .i_weight (w),
        .i_inhib  (inh),
        .i_thresh (thresh),
        .i_refrac (refrac),
        .o_spike  (spike),
        .o_clr    (clr),
        .o_do     (vdo),
        .o_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [10:0] a, input logic [10:0] x);
        n_checks++;
        if (a === x) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got do=%h spike=%b clr=%b busy=%b, need do=%h spike=%b clr=%b busy=%b",
                     nm, a[10:3], a[2], a[1], a[0], x[10:3], x[2], x[1], x[0]);
        end
    endtask

    // Monitor: every pushed expectation refers to the edge right after it was driven.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, {vdo, spike, clr, busy}, {e.vdo, e.sp, e.cl, e.bz});
            end
        end
    end

    // Drive one cycle of events at a falling edge and queue its expected result.
    task automatic step(input logic [3:0] e, input logic [3:0] ih, input logic [7:0] xdo,
                        input logic xs, input logic xc, input logic xb, input string nm);
        exp_t x;
        ev  = e;
        inh = ih;
        x.vdo = xdo; x.sp = xs; x.cl = xc; x.bz = xb; x.name = nm;
        q.push_back(x);
        @(negedge clk);
    endtask

    // Reset from a falling edge; leak counter restarts so edge n after return is step n.
    task automatic do_reset();
        rst = 1'b1;
        ev  = '0;
        inh = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Mid-cycle asynchronous reset with an immediate check of the outputs.
    task automatic mid_reset(input string nm);
        #2;
        rst = 1'b1;
        ev  = '0;
        #1;
        cmp(nm, {vdo, spike, clr, busy}, 11'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] lexp;
        logic [7:0] inh_exp;
        rst = 1'b1; ev = '0; w = '0; inh = '0; thresh = '0; refrac = '0;
        #1;
        cmp("reset_state", {vdo, spike, clr, busy}, 11'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: async reset from INTEG
        do_reset();
        thresh = 8'h90; refrac = 4'd0; w = 32'h0000_0080;
        step(4'b0001, 4'b0000, 8'h80, 0, 0, 0, "rst_load");
        mid_reset("rst_async");
        for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 8'h00, 0, 0, 0, "rst_after");

        // 2: integrate to threshold, refrac 0
        do_reset();
        thresh = 8'hC0; refrac = 4'd0; w = 32'h0000_0040;
        step(4'b0001, 4'b0000, 8'h40, 0, 0, 0, "integ_1");
        step(4'b0001, 4'b0000, 8'h80, 0, 0, 0, "integ_2");
        step(4'b0001, 4'b0000, 8'h00, 1, 1, 0, "integ_fire");
        step(4'b0001, 4'b0000, 8'h40, 0, 0, 0, "integ_after_fire");
        step(4'b0000, 4'b0000, 8'h40, 0, 0, 0, "integ_hold");

        // 3: parallel saturation, refractory 5
        do_reset();
        thresh = 8'hFF; refrac = 4'd5; w = 32'hFFFF_FFFF;
        step(4'b1111, 4'b0000, 8'h00, 1, 1, 1, "sat_fire");
        for (int i = 0; i < 4; i++) step(4'b1111, 4'b0000, 8'h00, 0, 0, 1, "refrac_busy");
        step(4'b1111, 4'b0000, 8'h00, 0, 0, 0, "refrac_exit");
        step(4'b1111, 4'b0000, 8'h00, 1, 1, 1, "refrac_refire");
        mid_reset("rst_in_refrac");
        step(4'b0000, 4'b0000, 8'h00, 0, 0, 0, "rst_refrac_after");

        // 4: leak down to zero without wrapping
        do_reset();
        thresh = 8'hFF; refrac = 4'd0; w = 32'h0000_0080;
        lexp = 8'h80;
        step(4'b0001, 4'b0000, 8'h80, 0, 0, 0, "leak_load");
        for (int n = 2; n <= 2080; n++) begin
            if ((n % 16) == 0 && lexp != 8'h00) begin
                lexp = lexp - (((lexp >> 6) == 8'h00) ? 8'h01 : (lexp >> 6));
            end
            step(4'b0000, 4'b0000, lexp, 0, 0, 0, (n == 16) ? "leak_first_tick" : "leak");
        end

        // 5: threshold 0 disables firing, vmem saturates
        do_reset();
        thresh = 8'h00; refrac = 4'd0; w = 32'h0000_00F0;
        step(4'b0001, 4'b0000, 8'hF0, 0, 0, 0, "dis_1");
        for (int i = 0; i < 4; i++) step(4'b0001, 4'b0000, 8'hFF, 0, 0, 0, "dis_sat");

        // 6: mixed excitatory/inhibitory in one cycle
        do_reset();
        thresh = 8'hFF; refrac = 4'd0; w = 32'h0000_0010;
        step(4'b0001, 4'b0000, 8'h10, 0, 0, 0, "inh_load");
        w = 32'h0000_5030;
`ifdef WLIF_INHIB_EN
        inh_exp = 8'h00;
`else
        inh_exp = 8'h90;
`endif
        step(4'b0011, 4'b0010, inh_exp, 0, 0, 0, "inh_mix");
        step(4'b0000, 4'b0000, inh_exp, 0, 0, 0, "inh_hold");

        @(posedge clk);
        #2;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expectations, need 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
